// File: rtl/pwm_pkg.sv
// Shared types for the PWM timebase: sequencer states and pwm_gen alignment codes.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Range alignment is any code with bit 1 set; FN_RANGE is its canonical form.
  typedef enum logic [1:0] {
    FN_LEFT  = 2'b00,
    FN_RIGHT = 2'b01,
    FN_RANGE = 2'b10
  } fn_align_e;

  function automatic fn_align_e decode_align(input logic [1:0] code);
    return code[1] ? FN_RANGE : fn_align_e'(code);
  endfunction

endpackage

// File: rtl/pwm_timer_ctrl_if.sv
// Register-side configuration bus plus the active set and timebase handed to pwm_gen.
interface pwm_timer_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
);
  logic             cfg_wr;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_compare1;
  logic [CNT_W-1:0] cfg_compare2;
  logic [7:0]       cfg_functions;
  logic             cfg_down;
  logic [PSC_W-1:0] cfg_prescale;
  logic             run;

  logic             pwm_en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] compare1;
  logic [CNT_W-1:0] compare2;
  logic [7:0]       functions;
  logic [CNT_W-1:0] count_val;
  logic             cycle_pulse;
  logic             upd_pending;
  logic             upd_done;

  modport master (
    output cfg_wr, cfg_period, cfg_compare1, cfg_compare2, cfg_functions,
           cfg_down, cfg_prescale, run,
    input  pwm_en, period, compare1, compare2, functions, count_val,
           cycle_pulse, upd_pending, upd_done
  );

  modport slave (
    input  cfg_wr, cfg_period, cfg_compare1, cfg_compare2, cfg_functions,
           cfg_down, cfg_prescale, run,
    output pwm_en, period, compare1, compare2, functions, count_val,
           cycle_pulse, upd_pending, upd_done
  );
endinterface

// File: rtl/pwm_prescaler.sv
// Clock divider: tick once every (prescale+1) clocks while enabled, held at 0 otherwise.
module pwm_prescaler #(
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PSC_W-1:0] prescale,
  output logic             tick
);

  logic [PSC_W-1:0] psc;

  // Using >= means a prescale lowered below psc still produces a tick and a wrap.
  assign tick = en && (psc >= prescale);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc <= '0;
    end else if (!en || tick) begin
      psc <= '0;
    end else begin
      psc <= psc + PSC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_timer_ctrl.sv
// PWM timebase sequencer: prescaled up/down counter, double-buffered config and start/stop FSM.
module pwm_timer_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
) (
  input logic              clk,
  input logic              rst,
  pwm_timer_ctrl_if.slave  bus
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] compare1;
    logic [CNT_W-1:0] compare2;
    logic [7:0]       functions;
    logic             down;
  } cfg_set_t;

  state_e           state;
  cfg_set_t         shadow;
  cfg_set_t         active;
  cfg_set_t         wr_set;
  cfg_set_t         next_active;
  logic [CNT_W-1:0] count_q;
  logic             pwm_en_q;
  logic             cycle_pulse_q;
  logic             upd_pending_q;
  logic             upd_done_q;

  logic             tick;
  logic             boundary;
  logic             activate;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] start_val;

  assign wr_set = cfg_set_t'{
    period:    bus.cfg_period,
    compare1:  bus.cfg_compare1,
    compare2:  bus.cfg_compare2,
    functions: bus.cfg_functions,
    down:      bus.cfg_down
  };

  pwm_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (state != ST_IDLE),
    .prescale (bus.cfg_prescale),
    .tick     (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    cnt_next = count_q;
    boundary = 1'b0;
    if (tick) begin
      if (active.period == '0) begin
        boundary = 1'b1;
        cnt_next = '0;
      end else if (!active.down) begin
        if (count_q >= active.period) begin
          boundary = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = count_q + CNT_W'(1);
        end
      end else begin
        if (count_q == '0) begin
          boundary = 1'b1;
          cnt_next = active.period;
        end else begin
          cnt_next = count_q - CNT_W'(1);
        end
      end
    end
  end

  // Boundaries only occur while counting, so IDLE activates on the clock after a write.
  always_comb begin
    activate    = upd_pending_q && ((state == ST_IDLE) || boundary);
    next_active = activate ? shadow : active;
    start_val   = next_active.down ? next_active.period : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      shadow        <= '0;
      active        <= '0;
      count_q       <= '0;
      pwm_en_q      <= 1'b0;
      cycle_pulse_q <= 1'b0;
      upd_pending_q <= 1'b0;
      upd_done_q    <= 1'b0;
    end else begin
      // pwm_gen ignores wraps of a zero period, so those never pulse.
      cycle_pulse_q <= boundary && (active.period != '0);
      upd_done_q    <= activate;

      if (activate) begin
        active        <= shadow;
        upd_pending_q <= 1'b0;
      end
      // A write landing on the activation cycle wins the pending flag and waits for the next one.
      if (bus.cfg_wr) begin
        shadow        <= wr_set;
        upd_pending_q <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          count_q <= start_val;
          if (bus.run) begin
            state    <= ST_RUN;
            pwm_en_q <= 1'b1;
          end
        end
        ST_RUN: begin
          count_q <= activate ? start_val : cnt_next;
          if (!bus.run) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          count_q <= activate ? start_val : cnt_next;
          if (bus.run) begin
            state <= ST_RUN;
          end else if (boundary) begin
            state    <= ST_IDLE;
            pwm_en_q <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          pwm_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pwm_en      = pwm_en_q;
  assign bus.period      = active.period;
  assign bus.compare1    = active.compare1;
  assign bus.compare2    = active.compare2;
  assign bus.functions   = active.functions;
  assign bus.count_val   = count_q;
  assign bus.cycle_pulse = cycle_pulse_q;
  assign bus.upd_pending = upd_pending_q;
  assign bus.upd_done    = upd_done_q;

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Directed bench for pwm_timer_ctrl: counting, prescaling, shadow updates, drain and reset.
module tb_pwm_timer_ctrl;

  localparam int CNT_W = 16;
  localparam int PSC_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  pwm_timer_ctrl_if #(.CNT_W(CNT_W), .PSC_W(PSC_W)) bus ();

  pwm_timer_ctrl #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst               = 1'b1;
    bus.cfg_wr        = 1'b0;
    bus.cfg_period    = '0;
    bus.cfg_compare1  = '0;
    bus.cfg_compare2  = '0;
    bus.cfg_functions = '0;
    bus.cfg_down      = 1'b0;
    bus.cfg_prescale  = '0;
    bus.run           = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic write_cfg(input logic [15:0] p, input logic [15:0] c1, input logic [15:0] c2,
                           input logic [7:0] fn, input logic down);
    bus.cfg_period    = p;
    bus.cfg_compare1  = c1;
    bus.cfg_compare2  = c2;
    bus.cfg_functions = fn;
    bus.cfg_down      = down;
    bus.cfg_wr        = 1'b1;
    step(1);
    bus.cfg_wr        = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({bus.pwm_en, bus.cycle_pulse, bus.upd_pending, bus.upd_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: en/pulse/pend/done=%b expected 0000",
               {bus.pwm_en, bus.cycle_pulse, bus.upd_pending, bus.upd_done});
    end
    n_cmp++;
    if (bus.count_val !== 16'd0 || bus.period !== 16'd0) begin
      n_err++;
      $display("FAIL reset_count: count=%0d period=%0d expected 0 0", bus.count_val, bus.period);
    end
    n_cmp++;
    if (bus.compare1 !== 16'd0 || bus.compare2 !== 16'd0 || bus.functions !== 8'd0) begin
      n_err++;
      $display("FAIL reset_cfg: c1=%0d c2=%0d fn=%0h expected 0 0 0",
               bus.compare1, bus.compare2, bus.functions);
    end
  endtask

  task automatic test_up_count();
    logic [15:0] exp_cnt [6];
    logic        exp_pls [6];
    exp_cnt = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1};
    exp_pls = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    write_cfg(16'd4, 16'd1, 16'd3, 8'h00, 1'b0);
    n_cmp++;
    if (bus.upd_pending !== 1'b1 || bus.period !== 16'd0) begin
      n_err++;
      $display("FAIL up_write_idle: pend=%b period=%0d expected 1 0", bus.upd_pending, bus.period);
    end
    step(1);
    n_cmp++;
    if (bus.period !== 16'd4 || bus.upd_done !== 1'b1 || bus.upd_pending !== 1'b0 || bus.pwm_en !== 1'b0) begin
      n_err++;
      $display("FAIL up_idle_activate: period=%0d done=%b pend=%b en=%b expected 4 1 0 0",
               bus.period, bus.upd_done, bus.upd_pending, bus.pwm_en);
    end
    bus.run = 1'b1;
    step(1);
    n_cmp++;
    if (bus.pwm_en !== 1'b1 || bus.count_val !== 16'd0) begin
      n_err++;
      $display("FAIL up_start: en=%b count=%0d expected 1 0", bus.pwm_en, bus.count_val);
    end
    for (int i = 0; i < 6; i++) begin
      step(1);
      n_cmp++;
      if (bus.count_val !== exp_cnt[i] || bus.cycle_pulse !== exp_pls[i]) begin
        n_err++;
        $display("FAIL up_seq[%0d]: count=%0d pulse=%b expected %0d %b",
                 i, bus.count_val, bus.cycle_pulse, exp_cnt[i], exp_pls[i]);
      end
    end
  endtask

  task automatic test_down_prescale();
    logic [15:0] exp_c;
    logic        exp_p;
    int          n_pulse;
    n_pulse = 0;
    apply_reset();
    bus.cfg_prescale = 8'd2;
    write_cfg(16'd3, 16'd1, 16'd2, 8'h00, 1'b1);
    step(1);
    n_cmp++;
    if (bus.count_val !== 16'd3 || bus.pwm_en !== 1'b0) begin
      n_err++;
      $display("FAIL down_idle_start: count=%0d en=%b expected 3 0", bus.count_val, bus.pwm_en);
    end
    bus.run = 1'b1;
    step(1);
    for (int k = 1; k <= 26; k++) begin
      step(1);
      exp_c = 16'(3 - (k % 12) / 3);
      exp_p = ((k % 12) == 0);
      if (bus.cycle_pulse === 1'b1) n_pulse++;
      n_cmp++;
      if (bus.count_val !== exp_c || bus.cycle_pulse !== exp_p) begin
        n_err++;
        $display("FAIL down_seq[%0d]: count=%0d pulse=%b expected %0d %b",
                 k, bus.count_val, bus.cycle_pulse, exp_c, exp_p);
      end
    end
    n_cmp++;
    if (n_pulse != 2) begin
      n_err++;
      $display("FAIL down_pulse_count: pulses=%0d expected 2", n_pulse);
    end
  endtask

  task automatic test_update_in_run();
    apply_reset();
    write_cfg(16'd9, 16'd3, 16'd7, 8'h01, 1'b0);
    step(1);
    bus.run = 1'b1;
    step(1);
    step(4);
    n_cmp++;
    if (bus.count_val !== 16'd4) begin
      n_err++;
      $display("FAIL run_upd_pre: count=%0d expected 4", bus.count_val);
    end
    write_cfg(16'd5, 16'd2, 16'd4, 8'h02, 1'b0);
    n_cmp++;
    if (bus.count_val !== 16'd5 || bus.upd_pending !== 1'b1 || bus.period !== 16'd9 || bus.compare1 !== 16'd3) begin
      n_err++;
      $display("FAIL run_upd_hold: count=%0d pend=%b period=%0d c1=%0d expected 5 1 9 3",
               bus.count_val, bus.upd_pending, bus.period, bus.compare1);
    end
    for (int i = 6; i <= 9; i++) begin
      step(1);
      n_cmp++;
      if (bus.count_val !== 16'(i) || bus.period !== 16'd9 || bus.upd_pending !== 1'b1 || bus.upd_done !== 1'b0) begin
        n_err++;
        $display("FAIL run_upd_wait[%0d]: count=%0d period=%0d pend=%b done=%b expected %0d 9 1 0",
                 i, bus.count_val, bus.period, bus.upd_pending, bus.upd_done, i);
      end
    end
    step(1);
    n_cmp++;
    if (bus.count_val !== 16'd0 || bus.cycle_pulse !== 1'b1 || bus.upd_done !== 1'b1 || bus.upd_pending !== 1'b0) begin
      n_err++;
      $display("FAIL run_upd_wrap: count=%0d pulse=%b done=%b pend=%b expected 0 1 1 0",
               bus.count_val, bus.cycle_pulse, bus.upd_done, bus.upd_pending);
    end
    n_cmp++;
    if (bus.period !== 16'd5 || bus.compare1 !== 16'd2 || bus.compare2 !== 16'd4 || bus.functions !== 8'h02) begin
      n_err++;
      $display("FAIL run_upd_values: period=%0d c1=%0d c2=%0d fn=%0h expected 5 2 4 2",
               bus.period, bus.compare1, bus.compare2, bus.functions);
    end
    step(1);
    n_cmp++;
    if (bus.count_val !== 16'd1 || bus.upd_done !== 1'b0) begin
      n_err++;
      $display("FAIL run_upd_after: count=%0d done=%b expected 1 0", bus.count_val, bus.upd_done);
    end
    step(4);
    n_cmp++;
    if (bus.count_val !== 16'd5 || bus.cycle_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL run_new_top: count=%0d pulse=%b expected 5 0", bus.count_val, bus.cycle_pulse);
    end
    step(1);
    n_cmp++;
    if (bus.count_val !== 16'd0 || bus.cycle_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL run_new_wrap: count=%0d pulse=%b expected 0 1", bus.count_val, bus.cycle_pulse);
    end
  endtask

  task automatic test_update_on_boundary();
    apply_reset();
    write_cfg(16'd3, 16'd0, 16'd0, 8'h00, 1'b0);
    step(1);
    bus.run = 1'b1;
    step(1);
    write_cfg(16'd2, 16'd1, 16'd1, 8'h01, 1'b0);
    n_cmp++;
    if (bus.count_val !== 16'd1 || bus.upd_pending !== 1'b1 || bus.period !== 16'd3) begin
      n_err++;
      $display("FAIL bnd_first_write: count=%0d pend=%b period=%0d expected 1 1 3",
               bus.count_val, bus.upd_pending, bus.period);
    end
    step(2);
    n_cmp++;
    if (bus.count_val !== 16'd3) begin
      n_err++;
      $display("FAIL bnd_top: count=%0d expected 3", bus.count_val);
    end
    write_cfg(16'd5, 16'd2, 16'd2, 8'h02, 1'b0);
    n_cmp++;
    if (bus.count_val !== 16'd0 || bus.period !== 16'd2 || bus.compare1 !== 16'd1 || bus.cycle_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL bnd_old_active: count=%0d period=%0d c1=%0d pulse=%b expected 0 2 1 1",
               bus.count_val, bus.period, bus.compare1, bus.cycle_pulse);
    end
    n_cmp++;
    if (bus.upd_done !== 1'b1 || bus.upd_pending !== 1'b1) begin
      n_err++;
      $display("FAIL bnd_flags: done=%b pend=%b expected 1 1", bus.upd_done, bus.upd_pending);
    end
    step(2);
    n_cmp++;
    if (bus.count_val !== 16'd2 || bus.period !== 16'd2 || bus.upd_pending !== 1'b1 || bus.upd_done !== 1'b0) begin
      n_err++;
      $display("FAIL bnd_between: count=%0d period=%0d pend=%b done=%b expected 2 2 1 0",
               bus.count_val, bus.period, bus.upd_pending, bus.upd_done);
    end
    step(1);
    n_cmp++;
    if (bus.count_val !== 16'd0 || bus.period !== 16'd5 || bus.compare1 !== 16'd2 ||
        bus.upd_done !== 1'b1 || bus.upd_pending !== 1'b0) begin
      n_err++;
      $display("FAIL bnd_new_active: count=%0d period=%0d c1=%0d done=%b pend=%b expected 0 5 2 1 0",
               bus.count_val, bus.period, bus.compare1, bus.upd_done, bus.upd_pending);
    end
  endtask

  task automatic test_drain();
    apply_reset();
    write_cfg(16'd6, 16'd2, 16'd4, 8'h00, 1'b0);
    step(1);
    bus.run = 1'b1;
    step(1);
    step(2);
    bus.run = 1'b0;
    step(1);
    n_cmp++;
    if (bus.count_val !== 16'd3 || bus.pwm_en !== 1'b1) begin
      n_err++;
      $display("FAIL drain_continue: count=%0d en=%b expected 3 1", bus.count_val, bus.pwm_en);
    end
    step(3);
    n_cmp++;
    if (bus.count_val !== 16'd6 || bus.pwm_en !== 1'b1) begin
      n_err++;
      $display("FAIL drain_top: count=%0d en=%b expected 6 1", bus.count_val, bus.pwm_en);
    end
    step(1);
    n_cmp++;
    if (bus.count_val !== 16'd0 || bus.pwm_en !== 1'b0 || bus.cycle_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL drain_exit: count=%0d en=%b pulse=%b expected 0 0 1",
               bus.count_val, bus.pwm_en, bus.cycle_pulse);
    end
    step(2);
    n_cmp++;
    if (bus.count_val !== 16'd0 || bus.pwm_en !== 1'b0) begin
      n_err++;
      $display("FAIL drain_idle: count=%0d en=%b expected 0 0", bus.count_val, bus.pwm_en);
    end
    bus.run = 1'b1;
    step(1);
    n_cmp++;
    if (bus.pwm_en !== 1'b1 || bus.count_val !== 16'd0) begin
      n_err++;
      $display("FAIL rearm_start: en=%b count=%0d expected 1 0", bus.pwm_en, bus.count_val);
    end
    step(2);
    bus.run = 1'b0;
    step(3);
    n_cmp++;
    if (bus.count_val !== 16'd5 || bus.pwm_en !== 1'b1) begin
      n_err++;
      $display("FAIL rearm_drain: count=%0d en=%b expected 5 1", bus.count_val, bus.pwm_en);
    end
    bus.run = 1'b1;
    step(2);
    n_cmp++;
    if (bus.count_val !== 16'd0 || bus.pwm_en !== 1'b1 || bus.cycle_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL rearm_wrap: count=%0d en=%b pulse=%b expected 0 1 1",
               bus.count_val, bus.pwm_en, bus.cycle_pulse);
    end
    step(1);
    n_cmp++;
    if (bus.count_val !== 16'd1 || bus.pwm_en !== 1'b1) begin
      n_err++;
      $display("FAIL rearm_keep: count=%0d en=%b expected 1 1", bus.count_val, bus.pwm_en);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    write_cfg(16'd9, 16'd3, 16'd3, 8'h01, 1'b0);
    step(1);
    bus.run = 1'b1;
    step(1);
    step(3);
    write_cfg(16'd4, 16'd1, 16'd1, 8'h00, 1'b0);
    n_cmp++;
    if (bus.count_val !== 16'd4 || bus.upd_pending !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: count=%0d pend=%b expected 4 1", bus.count_val, bus.upd_pending);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.count_val !== 16'd0 || bus.pwm_en !== 1'b0 || bus.upd_pending !== 1'b0 ||
        bus.period !== 16'd0 || bus.compare1 !== 16'd0 || bus.functions !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_async: count=%0d en=%b pend=%b period=%0d c1=%0d fn=%0h expected all 0",
               bus.count_val, bus.pwm_en, bus.upd_pending, bus.period, bus.compare1, bus.functions);
    end
    bus.run = 1'b0;
    #2;
    rst = 1'b0;
    step(1);
    n_cmp++;
    if (bus.upd_pending !== 1'b0 || bus.pwm_en !== 1'b0 || bus.count_val !== 16'd0) begin
      n_err++;
      $display("FAIL rstmid_release: pend=%b en=%b count=%0d expected 0 0 0",
               bus.upd_pending, bus.pwm_en, bus.count_val);
    end
    step(3);
    n_cmp++;
    if (bus.period !== 16'd0 || bus.upd_done !== 1'b0 || bus.pwm_en !== 1'b0 || bus.count_val !== 16'd0) begin
      n_err++;
      $display("FAIL rstmid_idle: period=%0d done=%b en=%b count=%0d expected 0 0 0 0",
               bus.period, bus.upd_done, bus.pwm_en, bus.count_val);
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_prescale();
    test_update_in_run();
    test_update_on_boundary();
    test_drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
